// File: rtl/alu_op_sequencer_if.sv
// Request/response channels between the issuing unit and alu_op_sequencer.
// The issuer uses the master modport and the sequencer uses the slave modport.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the TotalALU datapath: one request in, one response out, MULT run as reset/run/MFHI/MFLO.
// Optional macro ALU_SEQ_ILLEGAL_CHK_EN answers unknown function codes with rsp_err instead of driving the ALU.
module alu_op_sequencer #(
  parameter int ALU_LAT    = 1,
  parameter int MUL_CYCLES = 34
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_op_sequencer_if.slave   bus,
  output logic                busy,
  output logic                alu_reset,
  output logic [31:0]         alu_dataA,
  output logic [31:0]         alu_dataB,
  output logic [5:0]          alu_signal,
  input  logic [31:0]         alu_output
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAT_LD = CW'(ALU_LAT);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  localparam logic [5:0] F_MULT = 6'd25;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  typedef enum logic [2:0] {IDLE, EXEC, MRST, MRUN, MFHI, MFLO, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          alu_reset_d;
  logic [5:0]    sig_d;
  logic [31:0]   a_d, b_d;
  logic [31:0]   rsp_hi, rsp_hi_d, rsp_lo, rsp_lo_d;
  logic          rsp_err, rsp_err_d;
  logic          last;
  logic          illegal;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  function automatic logic is_legal(input logic [5:0] f);
    case (f)
      6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction
  assign illegal = !is_legal(bus.req_func);
`else
  assign illegal = 1'b0;
`endif

  assign last          = (cnt == ONE);
  assign busy          = (state != IDLE);
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_hi    = rsp_hi;
  assign bus.rsp_lo    = rsp_lo;
  assign bus.rsp_err   = rsp_err;

  // Every register holds by default; only the state being left or entered moves them.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    alu_reset_d = 1'b0;
    sig_d       = alu_signal;
    a_d         = alu_dataA;
    b_d         = alu_dataB;
    rsp_hi_d    = rsp_hi;
    rsp_lo_d    = rsp_lo;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          rsp_err_d = illegal;
          if (illegal) begin
            rsp_hi_d = '0;
            rsp_lo_d = '0;
            cnt_d    = '0;
            state_d  = RESP;
          end else begin
            a_d   = bus.req_a;
            b_d   = bus.req_b;
            sig_d = bus.req_func;
            if (bus.req_func == F_MULT) begin
              alu_reset_d = 1'b1;
              cnt_d       = ONE;
              state_d     = MRST;
            end else begin
              cnt_d   = LAT_LD;
              state_d = EXEC;
            end
          end
        end
      end
      EXEC: begin
        if (last) begin
          rsp_lo_d = alu_output;
          rsp_hi_d = '0;
          cnt_d    = '0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      MRST: begin
        cnt_d   = MUL_LD;
        state_d = MRUN;
      end
      MRUN: begin
        if (last) begin
          sig_d   = F_MFHI;
          cnt_d   = LAT_LD;
          state_d = MFHI;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      MFHI: begin
        if (last) begin
          rsp_hi_d = alu_output;
          sig_d    = F_MFLO;
          cnt_d    = LAT_LD;
          state_d  = MFLO;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      MFLO: begin
        if (last) begin
          rsp_lo_d = alu_output;
          cnt_d    = '0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset holds the ALU in reset too, so an aborted MULT leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_reset  <= 1'b1;
      alu_signal <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      alu_reset  <= alu_reset_d;
      alu_signal <= sig_d;
      alu_dataA  <= a_d;
      alu_dataB  <= b_d;
      rsp_hi     <= rsp_hi_d;
      rsp_lo     <= rsp_lo_d;
      rsp_err    <= rsp_err_d;
    end
  end

endmodule
